// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with architectural HI/LO.
// Ports: clk, reset (sync, high), start, MDOp[2:0], A, B -> busy, HI, LO.
// Define MDU_DIV_EN to build the divider (div/divu); otherwise they are no-ops.
module mdu #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ?
                        MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   a_q, b_q;
  logic [1:0]    op_q;

  logic go_mul, go_div, go_hi, go_lo;
  logic done;
  logic sgn;
  logic [63:0] ax, bx, prod;
  logic [31:0] quo, rem;

  // Requests are only honoured while idle.
  always_comb begin
    go_mul = 1'b0;
    go_div = 1'b0;
    go_hi  = 1'b0;
    go_lo  = 1'b0;
    if (state == IDLE && start) begin
      unique case (1'b1)
        (MDOp[2:1] == 2'b00): go_mul = 1'b1;
`ifdef MDU_DIV_EN
        (MDOp[2:1] == 2'b01): go_div = 1'b1;
`endif
        (MDOp == 3'b100):     go_hi  = 1'b1;
        (MDOp == 3'b101):     go_lo  = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (go_mul) begin
          state_n = RUN;
          cnt_n   = CW'(MUL_CYCLES);
        end else if (go_div) begin
          state_n = RUN;
          cnt_n   = CW'(DIV_CYCLES);
        end
      end
      RUN: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == RUN) && (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (go_mul || go_div) begin
      a_q  <= A;
      b_q  <= B;
      op_q <= MDOp[1:0];
    end
  end

  // op_q[0] clear selects the signed flavour.
  always_comb begin
    sgn  = ~op_q[0];
    ax   = {{32{sgn & a_q[31]}}, a_q};
    bx   = {{32{sgn & b_q[31]}}, b_q};
    prod = ax * bx;
  end

`ifdef MDU_DIV_EN
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, dvs, uq, ur;

  // Signed divide via magnitudes: INT_MIN/-1 falls out as 0x80000000 r 0.
  always_comb begin
    neg_a = sgn & a_q[31];
    neg_b = sgn & b_q[31];
    mag_a = neg_a ? -a_q : a_q;
    mag_b = neg_b ? -b_q : b_q;
    dvs   = (mag_b == '0) ? 32'd1 : mag_b;
    uq    = mag_a / dvs;
    ur    = mag_a % dvs;
    quo   = (neg_a ^ neg_b) ? -uq : uq;
    rem   = neg_a ? -ur : ur;
  end
`else
  always_comb begin
    quo = '0;
    rem = '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (done) begin
      if (!op_q[1]) begin
        HI <= prod[63:32];
        LO <= prod[31:0];
      end else if (b_q != '0) begin
        HI <= rem;
        LO <= quo;
      end
    end else if (go_hi) begin
      HI <= A;
    end else if (go_lo) begin
      LO <= A;
    end
  end

endmodule
